// File: rtl/dmem_dma.sv
// dmem_dma: block-copy bus initiator for the data-memory port.
// Copies len 32-bit words from src to dst, ascending, one read and one write
// per word, through the external req/gnt arbiter. Holds only a one-word buffer.
// Optional feature macro: DMA_FILL_EN (adds a fill mode that writes a latched
// pattern to every destination word without reading the source).
`timescale 1ns/1ps

module dmem_dma #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    input  logic              fill_mode,
    input  logic [31:0]       fill_val,
    output logic              busy,
    output logic              done,
    output logic              req,
    input  logic              gnt,
    output logic              we,
    output logic [ADDR_W-1:0] a,
    output logic [31:0]       wd,
    input  logic [31:0]       rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_sptr;
    logic [ADDR_W-1:0] r_dptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [31:0]       r_buf;
    logic              r_fill;

    logic [ADDR_W-1:0] w_srcAligned;
    logic [ADDR_W-1:0] w_dstAligned;
    logic              w_fillReq;
    logic [31:0]       w_fillData;
    logic              w_unusedBits;

    // The two low address bits never reach the bus: all transfers are word aligned.
    assign w_srcAligned = {src[ADDR_W-1:2], 2'b00};
    assign w_dstAligned = {dst[ADDR_W-1:2], 2'b00};

`ifdef DMA_FILL_EN
    // Fill requests are honoured; the pattern is captured into the word buffer at launch.
    assign w_fillReq    = fill_mode;
    assign w_fillData   = fill_val;
    assign w_unusedBits = ^{src[1:0], dst[1:0]};
`else
    // Fill inputs exist on the port list but every transfer is a plain copy.
    assign w_fillReq    = 1'b0;
    assign w_fillData   = 32'h0;
    assign w_unusedBits = ^{src[1:0], dst[1:0], fill_mode, fill_val};
`endif

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: a stalled grant simply holds the current state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        w_next = DONE;
                    end else if (w_fillReq) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            RD: begin
                if (gnt) begin
                    w_next = WR;
                end
            end
            WR: begin
                if (gnt) begin
                    if (r_cnt == LEN_W'(1)) begin
                        w_next = DONE;
                    end else if (r_fill) begin
                        w_next = WR;
                    end else begin
                        w_next = RD;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Pointers, word count and the single word buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sptr <= '0;
            r_dptr <= '0;
            r_cnt  <= '0;
            r_buf  <= 32'h0;
            r_fill <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sptr <= w_srcAligned;
                        r_dptr <= w_dstAligned;
                        r_cnt  <= len;
                        r_fill <= w_fillReq;
                        if (w_fillReq) begin
                            r_buf <= w_fillData;
                        end
                    end
                end
                RD: begin
                    if (gnt) begin
                        r_buf <= rd;
                    end
                end
                WR: begin
                    if (gnt) begin
                        r_sptr <= r_sptr + ADDR_W'(4);
                        r_dptr <= r_dptr + ADDR_W'(4);
                        r_cnt  <= r_cnt - LEN_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs are zero whenever this block is not the granted initiator,
    // so the arbiter can OR them with the processor's port.
    always_comb begin
        busy = (r_state == RD) || (r_state == WR);
        req  = busy;
        done = (r_state == DONE);
        we   = 1'b0;
        a    = '0;
        wd   = 32'h0;
        if (gnt) begin
            if (r_state == RD) begin
                a = r_sptr;
            end else if (r_state == WR) begin
                we = 1'b1;
                a  = r_dptr;
                wd = r_buf;
            end
        end
    end

endmodule

// File: tb/tb_dmem_dma.sv
// tb_dmem_dma: self-checking bench for dmem_dma.
// A 64-word RAM (aliased on address bits [7:2]) plus an LED register at
// 0xC000_0004 stand in for the data memory. A word-level transfer model
// predicts every bus cycle and the final memory image.
`timescale 1ns/1ps

module tb_dmem_dma;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic [31:0] src       = 32'h0;
    logic [31:0] dst       = 32'h0;
    logic [6:0]  len       = 7'h0;
    logic        fill_mode = 1'b0;
    logic [31:0] fill_val  = 32'h0;
    logic        gnt       = 1'b1;
    logic        busy;
    logic        done;
    logic        req;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;

    logic [31:0] ram [64];
    logic [31:0] leds;
    logic        tbWr   = 1'b0;
    logic [5:0]  tbIdx  = 6'h0;
    logic [31:0] tbData = 32'h0;

    int nCompared   = 0;
    int nMismatched = 0;

    // Model state: 0 idle, 1 moving words, 2 done pulse.
    int          mMode   = 0;
    int          mN      = 0;
    int          mK      = 0;
    bit          mFill   = 1'b0;
    logic [31:0] mS      = 32'h0;
    logic [31:0] mD      = 32'h0;
    logic [31:0] mFv     = 32'h0;
    logic [31:0] mdl [64];
    logic [31:0] mdlLeds = 32'h0;

    logic [31:0] aLog [8];
    int          aLogN = 0;

    dmem_dma #(.ADDR_W(32), .LEN_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .src(src), .dst(dst), .len(len),
        .fill_mode(fill_mode), .fill_val(fill_val), .busy(busy), .done(done),
        .req(req), .gnt(gnt), .we(we), .a(a), .wd(wd), .rd(rd)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    assign rd = ram[a[7:2]];

    // Data memory: DMA stores, the LED register, and bench preload writes.
    always @(posedge clk) begin
        if (reset) begin
            leds <= 32'h0;
        end else if (we) begin
            if (a == 32'hC000_0004) leds <= wd;
            else                    ram[a[7:2]] <= wd;
        end
        if (tbWr) ram[tbIdx] <= tbData;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record the addresses of granted bus cycles of the current transfer.
    always @(negedge clk) begin
        if (!busy && start) begin
            aLogN = 0;
        end else if (busy && gnt && aLogN < 8) begin
            aLog[aLogN] = a;
            aLogN++;
        end
    end

    // Cycle-by-cycle compare of every DUT output against the transfer model.
    always @(negedge clk) begin
        logic        expBusy;
        logic        expDone;
        logic        expWe;
        logic [31:0] expA;
        logic [31:0] expWd;
        logic [31:0] sAddr;
        logic [31:0] dAddr;
        bit          isWr;
        int          idx;
        expBusy = 1'b0; expDone = 1'b0; expWe = 1'b0;
        expA = 32'h0; expWd = 32'h0; isWr = 1'b0; idx = 0;
        sAddr = 32'h0; dAddr = 32'h0;
        if (reset) begin
            mMode   = 0;
            mdlLeds = 32'h0;
        end else begin
            expBusy = (mMode == 1);
            expDone = (mMode == 2);
            if (mMode == 1) begin
                isWr  = mFill || (mK % 2 == 1);
                idx   = mFill ? mK : mK / 2;
                sAddr = mS + 32'(4 * idx);
                dAddr = mD + 32'(4 * idx);
                if (gnt) begin
                    if (isWr) begin
                        expWe = 1'b1;
                        expA  = dAddr;
                        expWd = mFill ? mFv : mdl[sAddr[7:2]];
                    end else begin
                        expA = sAddr;
                    end
                end
            end
        end
        checkOutput("busy", 32'(busy), 32'(expBusy));
        checkOutput("req",  32'(req),  32'(expBusy));
        checkOutput("done", 32'(done), 32'(expDone));
        checkOutput("we",   32'(we),   32'(expWe));
        checkOutput("a",    a,         expA);
        checkOutput("wd",   wd,        expWd);
        if (!reset) begin
            case (mMode)
                0: begin
                    if (start) begin
                        mS  = {src[31:2], 2'b00};
                        mD  = {dst[31:2], 2'b00};
                        mN  = int'(len);
                        mK  = 0;
                        mFv = fill_val;
`ifdef DMA_FILL_EN
                        mFill = fill_mode;
`else
                        mFill = 1'b0;
`endif
                        mMode = (len == 7'h0) ? 2 : 1;
                    end
                end
                1: begin
                    if (gnt) begin
                        if (isWr) begin
                            if (dAddr == 32'hC000_0004) mdlLeds = expWd;
                            else                        mdl[dAddr[7:2]] = expWd;
                        end
                        mK++;
                        if (mK == (mFill ? mN : 2 * mN)) mMode = 2;
                    end
                end
                default: mMode = 0;
            endcase
        end
        if (tbWr) mdl[tbIdx] = tbData;
    end

    task automatic loadWord(input int idx, input logic [31:0] val);
        tbWr = 1'b1; tbIdx = 6'(idx); tbData = val;
        @(posedge clk); #1;
        tbWr = 1'b0;
    endtask

    task automatic checkMemory(input string tag);
        for (int i = 0; i < 64; i++) begin
            checkOutput($sformatf("%s.ram[%0d]", tag, i), ram[i], mdl[i]);
        end
        checkOutput($sformatf("%s.leds", tag), leds, mdlLeds);
    endtask

    // Launch one transfer (called at posedge+1 of an idle cycle) and wait for done.
    task automatic applyStimulus(input logic [31:0] s, input logic [31:0] d, input logic [6:0] n,
                                 input bit fm, input logic [31:0] fv, input logic [63:0] stallMask,
                                 input bit rndGnt, input bit noise,
                                 output int doneAt, output int busyCnt);
        int c;
        src = s; dst = d; len = n; fill_mode = fm; fill_val = fv; start = 1'b1; gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1; doneAt = -1; busyCnt = 0;
        while (doneAt < 0 && c < 2000) begin
            if (rndGnt) gnt = ($urandom_range(0, 3) != 0);
            else        gnt = (c < 64) ? !stallMask[c[5:0]] : 1'b1;
            if (noise) begin
                start = ($urandom_range(0, 7) == 0);
                src = $urandom; dst = $urandom; len = 7'($urandom);
                fill_mode = 1'($urandom); fill_val = $urandom;
            end
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) doneAt = c;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        gnt   = 1'b1;
        if (doneAt < 0) begin
            nCompared++;
            nMismatched++;
            $display("[TB] FAIL timeout: got no done expected done within 2000 cycles");
        end
    endtask

    initial begin
        int doneAt;
        int busyCnt;

        $display("[TB] reset");
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", 32'(busy), 32'h0);
        checkOutput("rst.done", 32'(done), 32'h0);
        checkOutput("rst.req",  32'(req),  32'h0);
        checkOutput("rst.we",   32'(we),   32'h0);
        checkOutput("rst.a",    a,         32'h0);
        checkOutput("rst.wd",   wd,        32'h0);
        reset = 1'b0;
        for (int i = 0; i < 64; i++) loadWord(i, $urandom);

        $display("[TB] basic copy");
        for (int i = 0; i < 4; i++) loadWord(i, 32'(i + 1));
        applyStimulus(32'h0, 32'h40, 7'd4, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("basic.doneAt",  32'(doneAt),  32'd9);
        checkOutput("basic.busyCnt", 32'(busyCnt), 32'd8);
        for (int i = 0; i < 4; i++) checkOutput("basic.data", ram[16 + i], 32'(i + 1));
        checkMemory("basic");

        $display("[TB] zero length back-to-back");
        applyStimulus(32'h0, 32'h40, 7'd0, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("zero.doneAt",  32'(doneAt),  32'd1);
        checkOutput("zero.busyCnt", 32'(busyCnt), 32'd0);

        $display("[TB] grant stall");
        loadWord(8, 32'hA1); loadWord(9, 32'hA2);
        applyStimulus(32'h20, 32'h60, 7'd2, 1'b0, 32'h0, 64'h1C, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("stall.doneAt", 32'(doneAt), 32'd8);
        checkOutput("stall.w0", ram[24], 32'hA1);
        checkOutput("stall.w1", ram[25], 32'hA2);
        checkMemory("stall");

        $display("[TB] misaligned source, LED target");
        loadWord(0, 32'h2A5);
        applyStimulus(32'h3, 32'hC000_0004, 7'd1, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("periph.leds",  leds,        32'h2A5);
        checkOutput("periph.nA",    32'(aLogN),  32'd2);
        checkOutput("periph.a0",    aLog[0],     32'h0);
        checkOutput("periph.a1",    aLog[1],     32'hC000_0004);
        checkOutput("periph.doneAt", 32'(doneAt), 32'd3);

        $display("[TB] address wrap");
        loadWord(62, 32'h6262); loadWord(63, 32'h6363); loadWord(0, 32'h0A00); loadWord(1, 32'h0101);
        applyStimulus(32'hFFFF_FFF8, 32'h80, 7'd4, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("wrap.w0", ram[32], 32'h6262);
        checkOutput("wrap.w2", ram[34], 32'h0A00);
        checkMemory("wrap");

        $display("[TB] overlapping ascending copy");
        loadWord(0, 32'h11); loadWord(1, 32'h22);
        applyStimulus(32'h0, 32'h8, 7'd6, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("overlap.w6", ram[6], 32'h11);
        checkOutput("overlap.w7", ram[7], 32'h22);
        checkMemory("overlap");

        $display("[TB] abort and restart");
        for (int i = 0; i < 4; i++) loadWord(4 + i, 32'h1111_0001 + 32'(i));
        loadWord(40, 32'h5555_0000);
        src = 32'h10; dst = 32'hA0; len = 7'd4; fill_mode = 1'b0; start = 1'b1; gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort.busy", 32'(busy), 32'h0);
        checkOutput("abort.we",   32'(we),   32'h0);
        checkOutput("abort.a",    a,         32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort.noWrite", ram[40], 32'h5555_0000);
        checkMemory("abort");
        applyStimulus(32'h10, 32'hA0, 7'd4, 1'b0, 32'h0, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("restart.doneAt", 32'(doneAt), 32'd9);
        checkOutput("restart.w0",     ram[40],     32'h1111_0001);
        checkMemory("restart");

`ifdef DMA_FILL_EN
        $display("[TB] fill");
        applyStimulus(32'h0, 32'h80, 7'd3, 1'b1, 32'hDEAD_BEEF, 64'h0, 1'b0, 1'b0, doneAt, busyCnt);
        checkOutput("fill.doneAt", 32'(doneAt), 32'd4);
        for (int i = 0; i < 3; i++) checkOutput("fill.data", ram[32 + i], 32'hDEAD_BEEF);
        checkMemory("fill");
`endif

        $display("[TB] randomized transfers");
        for (int t = 0; t < 24; t++) begin
            applyStimulus($urandom, $urandom, 7'($urandom_range(0, 24)), 1'($urandom),
                          $urandom, 64'h0, 1'b1, 1'b1, doneAt, busyCnt);
            checkMemory("rand");
        end
        applyStimulus($urandom, $urandom, 7'd127, 1'b0, 32'h0, 64'h0, 1'b1, 1'b1, doneAt, busyCnt);
        checkMemory("max");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dmem_dma.md
# dmem_dma

Memory-bus initiator that copies a block of 32-bit words from one data-memory region to another, using the same single-port bus the processor uses for loads and stores (`we`, `a`, `wd`, `rd`). It sits beside the processor and is muxed onto the data-memory port by an external arbiter through a `req`/`gnt` pair. It owns no storage beyond one word buffer; the memory and peripheral decode stay in the data memory.

## Interface
- `ADDR_W`, 32: bus address width; byte addresses.
- `LEN_W`, 7: transfer length width, in words. One transfer moves up to 127 words.
- `clk` input 1: single clock; every state change happens on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle launch pulse, sampled only in IDLE.
- `src` input ADDR_W: source byte address. Bits [1:0] are ignored (treated as 0).
- `dst` input ADDR_W: destination byte address. Bits [1:0] are ignored (treated as 0).
- `len` input LEN_W: number of words to move.
- `fill_mode` input 1: fill request (see Configuration).
- `fill_val` input 32: fill pattern (see Configuration).
- `busy` output 1: high in RD and WR.
- `done` output 1: one-cycle pulse when a transfer ends.
- `req` output 1: bus request to the arbiter; equals `busy`.
- `gnt` input 1: bus grant from the arbiter.
- `we` output 1: bus write enable.
- `a` output ADDR_W: bus address.
- `wd` output 32: bus write data.
- `rd` input 32: bus read data. It is combinational, valid in the same cycle `a` is driven.

## Operation
- FSM states: IDLE, RD, WR, DONE.
- **IDLE**
  - On `start`, latch `src & ~3`, `dst & ~3` and `len` into `sptr`, `dptr` and `cnt`.
  - Next state is RD if `len` != 0, otherwise DONE.
  - `start` in any other state is ignored.
- **RD**
  - With `gnt` = 1: drive `a` = `sptr`, `we` = 0. At the edge, `buf` <= `rd` and go to WR.
  - With `gnt` = 0: `a` = 0, `we` = 0, stay in RD.
- **WR**
  - With `gnt` = 1: drive `a` = `dptr`, `wd` = `buf`, `we` = 1.
  - At the edge: `sptr` += 4, `dptr` += 4, `cnt` -= 1. Go to DONE if `cnt` was 1, otherwise RD.
  - With `gnt` = 0: `we` = 0, `a` = 0, stay in WR; `buf` is held.
- **DONE:** `done` = 1 for exactly one cycle, then IDLE.
- When not actively driving the bus, `a` = 0, `wd` = 0, `we` = 0. The arbiter may OR/mux freely.
- Pointer arithmetic is modulo 2^ADDR_W; wrap past 0xFFFF_FFFC continues at 0x0000_0000.
- Copy order is ascending. When `dst` > `src` and the regions overlap, already-written words are re-read. This is defined behaviour, not an error.
- Target addresses are not range-checked. Writing 0xC000_0004, 0xC000_0008 or 0xC000_000C reaches LEDs, display and letter registers exactly as a processor store would.

## Timing
- Reset values: `busy` = 0, `done` = 0, `req` = 0, `we` = 0, `a` = 0, `wd` = 0. State IDLE, `buf` = 0, `cnt` = 0.
- `reset` asserted mid-transfer aborts on the spot. Words already written stay written; no rollback.
- With `gnt` held at 1, a transfer of N words (N > 0) takes:
  - RD in the cycle after the `start` edge;
  - 2 bus cycles per word;
  - `done` high in cycle 2N+1 after the `start` edge.
- With `len` = 0, `done` is high in the cycle right after the `start` edge, with no bus activity.
- Each cycle with `gnt` = 0 in RD or WR adds exactly one cycle of latency.
- `start` is accepted again in the cycle after `done`, i.e. back in IDLE.

## Configuration
- `DMA_FILL_EN` defined:
  - `fill_mode`, sampled with `start`, selects fill.
  - Fill skips RD: WR writes `fill_val` (latched at `start`) to `dptr` each granted cycle.
  - N words take N cycles; `src` is ignored.
- `DMA_FILL_EN` undefined:
  - `fill_mode` and `fill_val` exist but are ignored; every transfer is a copy.

## Test plan
- **Basic copy.** RAM[0..3] = 1, 2, 3, 4; `src` = 0x00, `dst` = 0x40, `len` = 4, `gnt` = 1.
  - RAM[16..19] = 1, 2, 3, 4.
  - `done` pulses 9 cycles after `start`; `busy` is high for 8 cycles.
- **Zero length.** `len` = 0 → `done` the next cycle; `we` never 1; `req` never 1.
- **Grant stall.** 2-word copy with `gnt` = 0 for 3 cycles in the first WR.
  - Data is correct.
  - `done` arrives at cycle 8 instead of 5.
  - No write occurs while `gnt` = 0.
- **Misaligned addresses and peripheral target.** `src` = 0x03, `dst` = 0xC000_0004, `len` = 1, RAM[0] = 0x2A5.
  - `leds` = 0x2A5.
  - Bus `a` sequence is 0x0, 0xC000_0004.
- **Abort and restart.** Assert `reset` in the first WR of a 4-word copy.
  - All outputs are 0 immediately and no write occurs.
  - A subsequent `start` runs normally.
- **Fill (with `DMA_FILL_EN`).** `fill_mode` = 1, `fill_val` = 0xDEADBEEF, `dst` = 0x80, `len` = 3.
  - RAM[32..34] = 0xDEADBEEF.
  - `done` arrives 4 cycles after `start`.
